// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: register address type and forwarding select encoding.
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b10,
    FWD_MEMWB = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX-stage source operand; EX/MEM result beats MEM/WB result.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] i_src_addr,
  input  logic          i_ex_mem_we,
  input  logic [AW-1:0] i_ex_mem_addr,
  input  logic          i_mem_wb_we,
  input  logic [AW-1:0] i_mem_wb_addr,
  output fwd_sel_e      o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_ex_mem_we && (i_ex_mem_addr != '0) && (i_ex_mem_addr == i_src_addr)) begin
      o_sel = FWD_EXMEM;
    end else if (i_mem_wb_we && (i_mem_wb_addr != '0) && (i_mem_wb_addr == i_src_addr)) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: pending-write scoreboard, mul/div occupancy, stall/flush priority, forwarding.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int MULDIV_LAT = 4,
  parameter  int CNT_W      = 32,
  localparam int AW         = $clog2(DATA_WIDTH),
  localparam int NREG       = 2 ** AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1_addr,
  input  logic [AW-1:0]   id_rs2_addr,
  input  logic            need_rs1,
  input  logic            need_rs2,
  input  logic [AW-1:0]   id_rd_addr,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic            id_is_muldiv,
  input  logic [AW-1:0]   id_ex_rs1_addr,
  input  logic [AW-1:0]   id_ex_rs2_addr,
  input  logic            id_ex_is_branch,
  input  logic            id_ex_is_jump,
  input  logic            B_taken,
  input  logic [AW-1:0]   ex_mem_reg_addr,
  input  logic            ex_mem_reg_write,
  input  logic [AW-1:0]   mem_wb_reg_addr,
  input  logic            mem_wb_reg_write,
  input  logic            mem_stall,
  input  logic            is_exception_commit,
  input  logic            is_mret_in_wb,
  output logic            stall_pc,
  output logic            stall_if_id,
  output logic            stall_id_ex,
  output logic            stall_ex_mem,
  output logic            stall_mem_wb,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            flush_ex_mem,
  output logic            flush_mem_wb,
  output logic            PC_Sel,
  output logic [1:0]      ALU_A_o,
  output logic [1:0]      ALU_B_o,
  output logic            muldiv_busy,
  output logic [NREG-1:0] pending_o,
  output logic [CNT_W-1:0] raw_stall_cnt,
  output logic [CNT_W-1:0] struct_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              MDW   = (MULDIV_LAT < 1) ? 1 : $clog2(MULDIV_LAT + 1);
  localparam logic [MDW-1:0]  LAT_V = MDW'(MULDIV_LAT);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;
  logic [NREG-1:0] w_pending_vis;
  logic [MDW-1:0]  r_cnt;
  logic [MDW-1:0]  w_cnt_nxt;
  logic [MDW-1:0]  w_cnt_vis;

  logic w_raw_hz;
  logic w_struct_hz;
  logic w_redirect;
  logic w_case_a;
  logic w_case_b;
  logic w_case_c;
  logic w_case_d;
  logic w_issue;
  logic w_set;

  fwd_sel_e w_fwd_a;
  fwd_sel_e w_fwd_b;

  // While rst is high the hazard logic already sees the cleared state, so no stale stall leaks out.
  assign w_pending_vis = rst ? '0 : r_pending;
  assign w_cnt_vis     = rst ? '0 : r_cnt;

  assign muldiv_busy = (w_cnt_vis != '0);
  assign pending_o   = w_pending_vis;

  assign w_raw_hz    = (need_rs1 && w_pending_vis[id_rs1_addr]) ||
                       (need_rs2 && w_pending_vis[id_rs2_addr]);
  assign w_struct_hz = id_valid && id_is_muldiv && muldiv_busy;
  assign w_redirect  = (B_taken && id_ex_is_branch) || id_ex_is_jump;

  assign w_case_a = is_exception_commit || is_mret_in_wb;
  assign w_case_b = !w_case_a && mem_stall;
  assign w_case_c = !w_case_a && !mem_stall && w_redirect;
  assign w_case_d = !w_case_a && !mem_stall && !w_redirect && (w_raw_hz || w_struct_hz);

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    PC_Sel       = 1'b0;
    if (w_case_a) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (w_case_b) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      stall_mem_wb = 1'b1;
    end else if (w_case_c) begin
      PC_Sel      = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (w_case_d) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  assign w_issue = id_valid && !stall_pc && !flush_if_id;
  assign w_set   = w_issue && id_reg_write && (id_is_load || id_is_muldiv);

  // Set is applied after clear so a same-register set wins; a commit-time flush overrides both.
  always_comb begin
    w_pending_nxt = r_pending;
    if (mem_wb_reg_write) begin
      w_pending_nxt[mem_wb_reg_addr] = 1'b0;
    end
    if (w_set) begin
      w_pending_nxt[id_rd_addr] = 1'b1;
    end
    if (w_case_a) begin
      w_pending_nxt = '0;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_case_a) begin
      w_cnt_nxt = '0;
    end else if (w_issue && id_is_muldiv) begin
      w_cnt_nxt = LAT_V;
    end else if ((r_cnt != '0) && !mem_stall) begin
      w_cnt_nxt = r_cnt - MDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  hazard_fwd_sel #(.AW(AW)) u_fwd_rs1 (
    .i_src_addr    (id_ex_rs1_addr),
    .i_ex_mem_we   (ex_mem_reg_write),
    .i_ex_mem_addr (ex_mem_reg_addr),
    .i_mem_wb_we   (mem_wb_reg_write),
    .i_mem_wb_addr (mem_wb_reg_addr),
    .o_sel         (w_fwd_a)
  );

  hazard_fwd_sel #(.AW(AW)) u_fwd_rs2 (
    .i_src_addr    (id_ex_rs2_addr),
    .i_ex_mem_we   (ex_mem_reg_write),
    .i_ex_mem_addr (ex_mem_reg_addr),
    .i_mem_wb_we   (mem_wb_reg_write),
    .i_mem_wb_addr (mem_wb_reg_addr),
    .o_sel         (w_fwd_b)
  );

  assign ALU_A_o = w_fwd_a;
  assign ALU_B_o = w_fwd_b;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_raw_cnt;
  logic [CNT_W-1:0] r_struct_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raw_cnt    <= '0;
      r_struct_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_case_d && w_raw_hz && (r_raw_cnt != '1)) begin
        r_raw_cnt <= r_raw_cnt + CNT_W'(1);
      end
      if (w_case_d && w_struct_hz && !w_raw_hz && (r_struct_cnt != '1)) begin
        r_struct_cnt <= r_struct_cnt + CNT_W'(1);
      end
      if ((w_case_a || w_case_c) && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign raw_stall_cnt    = r_raw_cnt;
  assign struct_stall_cnt = r_struct_cnt;
  assign flush_cnt        = r_flush_cnt;
`else
  assign raw_stall_cnt    = '0;
  assign struct_stall_cnt = '0;
  assign flush_cnt        = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios plus randomized traffic,
// with a behavioural reference model feeding an expected queue drained by a monitor.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int DATA_WIDTH = 32;
  localparam int MULDIV_LAT = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam int CNT_W = 4;
  localparam bit PERF  = 1'b1;
`else
  localparam int CNT_W = 32;
  localparam bit PERF  = 1'b0;
`endif
  localparam int AW   = 5;
  localparam int NREG = 32;

  localparam int OFF_FC   = 0;
  localparam int OFF_SC   = CNT_W;
  localparam int OFF_RC   = 2 * CNT_W;
  localparam int OFF_PEND = 3 * CNT_W;
  localparam int OFF_BUSY = OFF_PEND + NREG;
  localparam int OFF_FB   = OFF_BUSY + 1;
  localparam int OFF_FA   = OFF_FB + 2;
  localparam int OFF_CTRL = OFF_FA + 2;
  localparam int EXP_W    = OFF_CTRL + 10;

  localparam logic [CNT_W-1:0] RAW_SAT_EXP = PERF ? {CNT_W{1'b1}} : {CNT_W{1'b0}};

  logic clk = 1'b0;
  logic rst;
  logic id_valid, need_rs1, need_rs2, id_reg_write, id_is_load, id_is_muldiv;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [AW-1:0] id_ex_rs1_addr, id_ex_rs2_addr, ex_mem_reg_addr, mem_wb_reg_addr;
  logic id_ex_is_branch, id_ex_is_jump, B_taken, ex_mem_reg_write, mem_wb_reg_write;
  logic mem_stall, is_exception_commit, is_mret_in_wb;

  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, PC_Sel;
  logic [1:0] ALU_A_o, ALU_B_o;
  logic muldiv_busy;
  logic [NREG-1:0] pending_o;
  logic [CNT_W-1:0] raw_stall_cnt, struct_stall_cnt, flush_cnt;

  hazard_scoreboard #(
    .DATA_WIDTH (DATA_WIDTH),
    .MULDIV_LAT (MULDIV_LAT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk), .rst (rst),
    .id_valid (id_valid), .id_rs1_addr (id_rs1_addr), .id_rs2_addr (id_rs2_addr),
    .need_rs1 (need_rs1), .need_rs2 (need_rs2), .id_rd_addr (id_rd_addr),
    .id_reg_write (id_reg_write), .id_is_load (id_is_load), .id_is_muldiv (id_is_muldiv),
    .id_ex_rs1_addr (id_ex_rs1_addr), .id_ex_rs2_addr (id_ex_rs2_addr),
    .id_ex_is_branch (id_ex_is_branch), .id_ex_is_jump (id_ex_is_jump), .B_taken (B_taken),
    .ex_mem_reg_addr (ex_mem_reg_addr), .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_reg_addr (mem_wb_reg_addr), .mem_wb_reg_write (mem_wb_reg_write),
    .mem_stall (mem_stall), .is_exception_commit (is_exception_commit),
    .is_mret_in_wb (is_mret_in_wb),
    .stall_pc (stall_pc), .stall_if_id (stall_if_id), .stall_id_ex (stall_id_ex),
    .stall_ex_mem (stall_ex_mem), .stall_mem_wb (stall_mem_wb),
    .flush_if_id (flush_if_id), .flush_id_ex (flush_id_ex), .flush_ex_mem (flush_ex_mem),
    .flush_mem_wb (flush_mem_wb), .PC_Sel (PC_Sel),
    .ALU_A_o (ALU_A_o), .ALU_B_o (ALU_B_o), .muldiv_busy (muldiv_busy), .pending_o (pending_o),
    .raw_stall_cnt (raw_stall_cnt), .struct_stall_cnt (struct_stall_cnt), .flush_cnt (flush_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model state
  bit     m_pend [NREG];
  int     m_cnt;
  longint m_raw, m_str, m_fl;
  longint cnt_max = (64'd1 << CNT_W) - 1;

  logic [EXP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
    if (ex_mem_reg_write && ex_mem_reg_addr != 0 && ex_mem_reg_addr == src) return 2'b10;
    if (mem_wb_reg_write && mem_wb_reg_addr != 0 && mem_wb_reg_addr == src) return 2'b11;
    return 2'b00;
  endfunction

  task automatic idle();
    id_valid = 0; need_rs1 = 0; need_rs2 = 0; id_reg_write = 0; id_is_load = 0; id_is_muldiv = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_ex_rs1_addr = 0; id_ex_rs2_addr = 0; id_ex_is_branch = 0; id_ex_is_jump = 0; B_taken = 0;
    ex_mem_reg_addr = 0; ex_mem_reg_write = 0; mem_wb_reg_addr = 0; mem_wb_reg_write = 0;
    mem_stall = 0; is_exception_commit = 0; is_mret_in_wb = 0;
  endtask

  // Driver: predict this cycle's outputs, queue them, then advance the model across the edge.
  task automatic step();
    logic [NREG-1:0] pv;
    logic busy, raw, str, exc, red, issue;
    logic spc, sif, sid, sem, smw, fif, fie, fem, fmw, pcs;
    exc = is_exception_commit || is_mret_in_wb;
    for (int i = 0; i < NREG; i++) pv[i] = !rst && m_pend[i];
    busy = !rst && (m_cnt > 0);
    raw  = (need_rs1 && pv[id_rs1_addr]) || (need_rs2 && pv[id_rs2_addr]);
    str  = id_valid && id_is_muldiv && busy;
    red  = (B_taken && id_ex_is_branch) || id_ex_is_jump;
    {spc, sif, sid, sem, smw, fif, fie, fem, fmw, pcs} = '0;
    if (exc) {fif, fie, fem, fmw} = 4'hF;
    else if (mem_stall) {spc, sif, sid, sem, smw} = 5'h1F;
    else if (red) {pcs, fif, fie} = 3'b111;
    else if (raw || str) {spc, sif, fie} = 3'b111;
    exp_q.push_back({spc, sif, sid, sem, smw, fif, fie, fem, fmw, pcs,
                     model_fwd(id_ex_rs1_addr), model_fwd(id_ex_rs2_addr), busy, pv,
                     CNT_W'(m_raw), CNT_W'(m_str), CNT_W'(m_fl)});
    issue = id_valid && !spc && !fif;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_pend[i] = 0;
      m_cnt = 0; m_raw = 0; m_str = 0; m_fl = 0;
    end else begin
      if (PERF) begin
        if (!exc && !mem_stall && !red && raw && m_raw < cnt_max) m_raw++;
        if (!exc && !mem_stall && !red && str && !raw && m_str < cnt_max) m_str++;
        if ((exc || (!mem_stall && red)) && m_fl < cnt_max) m_fl++;
      end
      if (exc) begin
        for (int i = 0; i < NREG; i++) m_pend[i] = 0;
        m_cnt = 0;
      end else begin
        if (mem_wb_reg_write) m_pend[mem_wb_reg_addr] = 0;
        if (issue && id_reg_write && (id_is_load || id_is_muldiv) && id_rd_addr != 0)
          m_pend[id_rd_addr] = 1;
        if (issue && id_is_muldiv) m_cnt = MULDIV_LAT;
        else if (m_cnt > 0 && !mem_stall) m_cnt--;
      end
    end
    #1;
  endtask

  // Monitor: every cycle the DUT presents a full output vector; compare against the queue head.
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl", 64'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                         flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, PC_Sel}),
            64'(e[OFF_CTRL +: 10]));
        chk("fwd", 64'({ALU_A_o, ALU_B_o}), 64'({e[OFF_FA +: 2], e[OFF_FB +: 2]}));
        chk("busy", 64'(muldiv_busy), 64'(e[OFF_BUSY]));
        chk("pending", 64'(pending_o), 64'(e[OFF_PEND +: NREG]));
        chk("perf", 64'({raw_stall_cnt, struct_stall_cnt, flush_cnt}) , 64'(e[OFF_FC +: 3*CNT_W]));
      end
    end
  end

  task automatic issue_load(input logic [AW-1:0] rd);
    idle(); id_valid = 1; id_rd_addr = rd; id_reg_write = 1; id_is_load = 1; step();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) m_pend[i] = 0;
    m_cnt = 0; m_raw = 0; m_str = 0; m_fl = 0;
    idle(); rst = 1;
    @(posedge clk); #1;
    step(); step();
    rst = 0; idle(); #2;
    chk("reset_pending", 64'(pending_o), 64'd0);
    chk("reset_busy", 64'(muldiv_busy), 64'd0);
    step();

    // Load-use on x5
    issue_load(5);
    idle(); id_valid = 1; need_rs1 = 1; id_rs1_addr = 5; id_rd_addr = 8; id_reg_write = 1; #2;
    chk("lu_stall_pc", 64'(stall_pc), 64'd1);
    chk("lu_flush_id_ex", 64'(flush_id_ex), 64'd1);
    chk("lu_pend5", 64'(pending_o[5]), 64'd1);
    step(); step();
    mem_wb_reg_write = 1; mem_wb_reg_addr = 5; #2;
    chk("lu_stall_wb_cycle", 64'(stall_pc), 64'd1);
    step();
    mem_wb_reg_write = 0; #2;
    chk("lu_release", 64'(stall_pc), 64'd0);
    step();

    // Back-to-back mul/div
    idle(); id_valid = 1; id_is_muldiv = 1; id_reg_write = 1; id_rd_addr = 6; step();
    id_rd_addr = 10;
    for (int i = 0; i < MULDIV_LAT; i++) begin
      #2; chk("struct_stall", 64'(stall_pc), 64'd1); step();
    end
    #2; chk("struct_issue", 64'(stall_pc), 64'd0); step();
    idle();
    for (int i = 0; i < MULDIV_LAT; i++) begin
      #2; chk("busy_hold", 64'(muldiv_busy), 64'd1); step();
    end
    #2; chk("busy_fall", 64'(muldiv_busy), 64'd0); step();

    // Taken branch in EX beats RAW in ID
    issue_load(5);
    idle(); id_valid = 1; need_rs1 = 1; id_rs1_addr = 5; id_ex_is_branch = 1; B_taken = 1; #2;
    chk("br_pc_sel", 64'(PC_Sel), 64'd1);
    chk("br_flush_if_id", 64'(flush_if_id), 64'd1);
    chk("br_stall_pc", 64'(stall_pc), 64'd0);
    step();

    // Exception commit with pending[7] and counter at 2
    issue_load(7);
    idle(); id_valid = 1; id_is_muldiv = 1; id_reg_write = 1; id_rd_addr = 12; step();
    idle(); step(); step();
    is_exception_commit = 1; #2;
    chk("exc_pend7", 64'(pending_o[7]), 64'd1);
    chk("exc_flushes", 64'({flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}), 64'hF);
    step();
    idle(); #2;
    chk("exc_pend_clear", 64'(pending_o), 64'd0);
    chk("exc_busy_clear", 64'(muldiv_busy), 64'd0);
    step();

    // Forwarding
    idle(); ex_mem_reg_write = 1; ex_mem_reg_addr = 3; mem_wb_reg_write = 1; mem_wb_reg_addr = 3;
    id_ex_rs1_addr = 3; #2;
    chk("fwd_exmem", 64'(ALU_A_o), 64'h2);
    step();
    ex_mem_reg_write = 0; id_ex_rs2_addr = 3; #2;
    chk("fwd_memwb", 64'(ALU_B_o), 64'h3);
    step();
    ex_mem_reg_write = 1; ex_mem_reg_addr = 0; mem_wb_reg_addr = 0; id_ex_rs1_addr = 0; #2;
    chk("fwd_x0", 64'(ALU_A_o), 64'h0);
    step();

    // Reset mid-operation discards pending state
    issue_load(9);
    idle(); rst = 1; id_valid = 1; need_rs1 = 1; id_rs1_addr = 9; #2;
    chk("rst_no_stall", 64'(stall_pc), 64'd0);
    step();
    rst = 0; #2;
    chk("post_rst_no_stall", 64'(stall_pc), 64'd0);
    step();

    // 20 RAW stall cycles
    issue_load(5);
    idle(); id_valid = 1; need_rs2 = 1; id_rs2_addr = 5;
    for (int i = 0; i < 20; i++) step();
    #2;
    chk("perf_raw_sat", 64'(raw_stall_cnt), 64'(RAW_SAT_EXP));
    chk("perf_struct", 64'(struct_stall_cnt), 64'd0);
    chk("perf_flush", 64'(flush_cnt), 64'd0);
    step();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst                 = ($urandom_range(0, 199) == 0);
      id_valid            = ($urandom_range(0, 3) != 0);
      id_rs1_addr         = 5'($urandom_range(0, 7));
      id_rs2_addr         = 5'($urandom_range(0, 7));
      id_rd_addr          = 5'($urandom_range(0, 7));
      need_rs1            = ($urandom_range(0, 1) == 1);
      need_rs2            = ($urandom_range(0, 1) == 1);
      id_reg_write        = ($urandom_range(0, 3) != 0);
      id_is_load          = ($urandom_range(0, 3) == 0);
      id_is_muldiv        = !id_is_load && ($urandom_range(0, 5) == 0);
      id_ex_rs1_addr      = 5'($urandom_range(0, 7));
      id_ex_rs2_addr      = 5'($urandom_range(0, 7));
      id_ex_is_branch     = ($urandom_range(0, 7) == 0);
      B_taken             = ($urandom_range(0, 1) == 1);
      id_ex_is_jump       = ($urandom_range(0, 15) == 0);
      ex_mem_reg_write    = ($urandom_range(0, 1) == 1);
      ex_mem_reg_addr     = 5'($urandom_range(0, 7));
      mem_wb_reg_write    = ($urandom_range(0, 1) == 1);
      mem_wb_reg_addr     = 5'($urandom_range(0, 7));
      mem_stall           = ($urandom_range(0, 9) == 0);
      is_exception_commit = ($urandom_range(0, 59) == 0);
      is_mret_in_wb       = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 0; idle();

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
